// File: rtl/apb_node_tmo.sv
// apb_node_tmo: one-to-many APB node. It decodes the upstream address onto one of NB_SLAVE
// downstream slaves and answers an unmapped address with an error. A transfer whose
// slave stalls too long is also answered with an error.
//
// Ports
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   paddr_i/pwdata_i/pwrite_i         upstream address, write data, direction
//   psel_i/penable_i                  upstream select and enable
//   prdata_o/pready_o/pslverr_o       upstream response
//   paddr_o/pwdata_o/pwrite_o         broadcast to all slaves, combinational copy of upstream
//   psel_o/penable_o                  per-slave select and enable
//   prdata_i/pready_i/pslverr_i       per-slave response, slave k in slice k
//   err_irq_o                         one-cycle pulse after each error the node generates
//   err_addr_o                        paddr of the most recent node-generated error
//   tmo_cnt_o                         saturating count of timeouts since reset
module apb_node_tmo #(
  parameter int unsigned NB_SLAVE       = 10,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] START_ADDR = {
    32'h1A10_9000, 32'h1A10_8000, 32'h1A10_7000, 32'h1A10_6000, 32'h1A10_5000,
    32'h1A10_4000, 32'h1A10_3000, 32'h1A10_2000, 32'h1A10_1000, 32'h1A10_0000},
  parameter logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] END_ADDR = {
    32'h1A10_9FFF, 32'h1A10_8FFF, 32'h1A10_7FFF, 32'h1A10_6FFF, 32'h1A10_5FFF,
    32'h1A10_4FFF, 32'h1A10_3FFF, 32'h1A10_2FFF, 32'h1A10_1FFF, 32'h1A10_0FFF}
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  // upstream
  input  logic [APB_ADDR_WIDTH-1:0]          paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]          pwdata_i,
  input  logic                               pwrite_i,
  input  logic                               psel_i,
  input  logic                               penable_i,
  output logic [APB_DATA_WIDTH-1:0]          prdata_o,
  output logic                               pready_o,
  output logic                               pslverr_o,
  // downstream
  output logic [APB_ADDR_WIDTH-1:0]          paddr_o,
  output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
  output logic                               pwrite_o,
  output logic [NB_SLAVE-1:0]                psel_o,
  output logic [NB_SLAVE-1:0]                penable_o,
  input  logic [NB_SLAVE*APB_DATA_WIDTH-1:0] prdata_i,
  input  logic [NB_SLAVE-1:0]                pready_i,
  input  logic [NB_SLAVE-1:0]                pslverr_i,
  // error reporting
  output logic                               err_irq_o,
  output logic [APB_ADDR_WIDTH-1:0]          err_addr_o,
  output logic [7:0]                         tmo_cnt_o
);

  localparam int unsigned SelW = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TmoEn = (TIMEOUT_CYCLES != 0);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDecErr
  } state_e;

  state_e                    state_q;
  logic [SelW-1:0]           sel_q;
  logic [CntW-1:0]           cnt_q;
  logic                      err_irq_q;
  logic [APB_ADDR_WIDTH-1:0] err_addr_q;
  logic [7:0]                tmo_cnt_q;

  logic                      hit_any;
  logic [SelW-1:0]           hit_idx;
  logic [NB_SLAVE-1:0]       hit_oh;
  logic [NB_SLAVE-1:0]       sel_oh;
  logic                      sel_pready;
  logic                      sel_pslverr;
  logic [APB_DATA_WIDTH-1:0] sel_prdata;
  logic                      tmo_hit;
  logic                      decerr_done;
  logic                      err_evt;

  assign paddr_o  = paddr_i;
  assign pwdata_o = pwdata_i;
  assign pwrite_o = pwrite_i;

  // Address decode. Scanning from the top index down lets the lowest matching slave
  // win on overlapping ranges.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = int'(NB_SLAVE) - 1; k >= 0; k--) begin
      if (paddr_i >= START_ADDR[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] &&
          paddr_i <= END_ADDR[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) begin
        hit_any = 1'b1;
        hit_idx = SelW'(k);
      end
    end
    // Only the winner is selected, so overlapping ranges never select two slaves at once.
    hit_oh = '0;
    for (int k = 0; k < int'(NB_SLAVE); k++) begin
      hit_oh[k] = hit_any && (hit_idx == SelW'(k));
    end
  end

  // Response mux for the slave latched at the setup phase.
  always_comb begin
    sel_oh      = '0;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int k = 0; k < int'(NB_SLAVE); k++) begin
      if (sel_q == SelW'(k)) begin
        sel_oh[k]   = 1'b1;
        sel_pready  = pready_i[k];
        sel_pslverr = pslverr_i[k];
        sel_prdata  = prdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      end
    end
  end

  // The counter holds the number of stalled access cycles already seen, so the cycle
  // in which it reads TIMEOUT_CYCLES-1 is the last one allowed. A slave answering in that
  // same cycle takes priority.
  assign tmo_hit = TmoEn && (state_q == StAccess) && psel_i && penable_i && !sel_pready &&
                   (cnt_q == CntLast);
  assign decerr_done = (state_q == StDecErr) && psel_i && penable_i;
  assign err_evt     = tmo_hit || decerr_done;

  // Upstream and downstream handshake outputs. Everything is forced low while reset is
  // held, including the setup-phase select that would otherwise pass straight through in IDLE.
  always_comb begin
    psel_o    = '0;
    penable_o = '0;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    prdata_o  = '0;
    if (!rst_i) begin
      unique case (state_q)
        StIdle: begin
          if (psel_i) psel_o = hit_oh;
        end
        StAccess: begin
          if (tmo_hit) begin
            pready_o  = 1'b1;
            pslverr_o = 1'b1;
          end else begin
            psel_o    = psel_i    ? sel_oh : '0;
            penable_o = penable_i ? sel_oh : '0;
            pready_o  = sel_pready;
            pslverr_o = sel_pslverr;
            prdata_o  = sel_prdata;
          end
        end
        StDecErr: begin
          if (psel_i && penable_i) begin
            pready_o  = 1'b1;
            pslverr_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      cnt_q      <= '0;
      err_irq_q  <= 1'b0;
      err_addr_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      err_irq_q <= err_evt;
      if (err_evt) err_addr_q <= paddr_i;
      if (tmo_hit && tmo_cnt_q != 8'hFF) tmo_cnt_q <= tmo_cnt_q + 8'd1;

      unique case (state_q)
        StIdle: begin
          if (psel_i && !penable_i) begin
            if (hit_any) begin
              sel_q   <= hit_idx;
              cnt_q   <= '0;
              state_q <= StAccess;
            end else begin
              state_q <= StDecErr;
            end
          end
        end
        StAccess: begin
          if (!psel_i) begin
            // Master abandoned the transfer: quietly drop it.
            cnt_q   <= '0;
            state_q <= StIdle;
          end else if (penable_i) begin
            if (sel_pready || tmo_hit) begin
              cnt_q   <= '0;
              state_q <= StIdle;
            end else if (cnt_q != CntMax) begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StDecErr: begin
          if (!psel_i || penable_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign err_irq_o  = err_irq_q;
  assign err_addr_o = err_addr_q;
  assign tmo_cnt_o  = tmo_cnt_q;

endmodule

// File: doc/apb_node_tmo.md
APB_NODE_TMO -- requirements
Module: apb_node_tmo

Interface
REQ-001 Parameter NB_SLAVE, default 10: number of downstream APB slave ports, range 1..16.
REQ-002 Parameter APB_ADDR_WIDTH, default 32: address width.
REQ-003 Parameter APB_DATA_WIDTH, default 32: data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 255: access-phase cycles before forced error; 0 disables timeout.
REQ-005 Parameter START_ADDR / END_ADDR, NB_SLAVE*APB_ADDR_WIDTH packed: inclusive range per slave; slave k occupies slice k.
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 clk_i  in  1  clock; all state updates on rising edge.
REQ-008 rst_i  in  1  asynchronous active-high reset.
REQ-009 paddr_i, pwdata_i  in  APB_ADDR_WIDTH / APB_DATA_WIDTH  upstream address, write data.
REQ-010 pwrite_i, psel_i, penable_i  in  1 each  upstream control.
REQ-011 prdata_o  out  APB_DATA_WIDTH; pready_o, pslverr_o  out  1 each  upstream response.
REQ-012 paddr_o, pwdata_o, pwrite_o  out  APB_ADDR_WIDTH / APB_DATA_WIDTH / 1  broadcast to all slaves.
REQ-013 psel_o, penable_o  out  NB_SLAVE  per-slave select/enable.
REQ-014 prdata_i  in  NB_SLAVE*APB_DATA_WIDTH; pready_i, pslverr_i  in  NB_SLAVE  per-slave response.
REQ-015 err_irq_o  out  1  one-cycle pulse per node-generated error.
REQ-016 err_addr_o  out  APB_ADDR_WIDTH  paddr of most recent node-generated error.
REQ-017 tmo_cnt_o  out  8  saturating count of timeouts since reset.

Function
REQ-018 paddr_o, pwdata_o, pwrite_o shall equal paddr_i, pwdata_i, pwrite_i combinationally at all times.
REQ-019 Decode: hit_k = START_ADDR[k] <= paddr_i <= END_ADDR[k]; on overlapping hits the lowest index wins.
REQ-020 FSM states IDLE, ACCESS, DECERR; reset state IDLE.
REQ-021 IDLE: psel_o[k] = psel_i & hit_k (setup phase forwarded same cycle); penable_o all 0; pready_o=0.
REQ-022 IDLE, psel_i=1 & penable_i=0 & some hit: register sel_q=winning index, clear counter, go ACCESS.
REQ-023 IDLE, psel_i=1 & penable_i=0 & no hit: go DECERR, no psel_o asserted.
REQ-024 ACCESS: psel_o[sel_q]=psel_i, penable_o[sel_q]=penable_i, others 0; prdata_o, pready_o, pslverr_o = slice sel_q of slave inputs.
REQ-025 ACCESS, penable_i=1 & pready_i[sel_q]=1: transfer completes, go IDLE.
REQ-026 ACCESS, penable_i=1 & pready_i[sel_q]=0: counter increments; counter saturates at TIMEOUT_CYCLES.
REQ-027 Timeout: in the access cycle where counter==TIMEOUT_CYCLES-1 and pready_i[sel_q]=0 (TIMEOUT_CYCLES!=0), node drives pready_o=1, pslverr_o=1, prdata_o=0, psel_o/penable_o all 0, goes IDLE; i.e. the Nth stalled access cycle is answered.
REQ-028 Slave pready arriving in the same cycle as timeout: slave response wins, no timeout recorded.
REQ-029 DECERR: pready_o=1, pslverr_o=1, prdata_o=0 in the access cycle (penable_i=1), then IDLE; 0 wait states.
REQ-030 Any node-generated error (timeout or DECERR): err_irq_o=1 the following cycle for exactly one cycle; err_addr_o updated with paddr_i on the same edge.
REQ-031 Timeout only: tmo_cnt_o increments by 1, holding at 255.
REQ-032 psel_i dropping while in ACCESS or DECERR (protocol violation): return to IDLE next edge, counter cleared, no error flagged.
REQ-033 Back-to-back transfers: a new setup phase in the cycle after completion is accepted from IDLE without a bubble.

Reset
REQ-034 On rst_i=1, asynchronously: state IDLE, sel_q=0, counter=0, err_irq_o=0, err_addr_o=0, tmo_cnt_o=0.
REQ-035 During reset all psel_o, penable_o, pready_o, pslverr_o shall be 0 and prdata_o 0.
REQ-036 Reset asserted mid-transfer aborts it; first post-reset cycle in IDLE, downstream selects 0.

Verification
REQ-037 Write 0x1A10_3004=0xDEADBEEF, timer slot 3 ready immediately -> psel_o=0x008, 2-cycle transfer, pslverr_o=0, no irq.
REQ-038 Read 0x1A10_1000, slot 1 stalls 3 cycles, prdata_i=0x55 -> pready_o 4th access cycle, prdata_o=0x55, counter clears.
REQ-039 Read 0x1A20_0000 (unmapped) -> no psel_o, pready_o=pslverr_o=1 in access cycle, err_irq_o pulse, err_addr_o=0x1A20_0000.
REQ-040 TIMEOUT_CYCLES=4, slave never ready -> 4th access cycle pready_o=pslverr_o=1, prdata_o=0, psel_o dropped, tmo_cnt_o=1.
REQ-041 TIMEOUT_CYCLES=4, slave ready exactly in 4th cycle -> slave data returned, pslverr_o=pslverr_i, tmo_cnt_o unchanged.
REQ-042 rst_i pulsed during stalled access -> outputs 0 asynchronously; next transfer to 0x1A10_0000 completes normally.
